// File: rtl/branch_pred_lht_pkg.sv
// Types and sizing shared between the fetch-side branch predictor and decode_info.
package rv32i_types;

    localparam int          IDX_BITS  = 8;
    localparam int          HIST_BITS = 8;
    localparam logic [1:0]  PHT_INIT  = 2'b01;

    typedef struct packed {
        logic                 bp;
        logic [31:0]          bp_addr;
        logic                 lht_valid;
        logic [HIST_BITS-1:0] lht_true;
    } bp_pred_t;

endpackage

// File: rtl/branch_pred_lht_sat_ctr2.sv
// Next-state function of a 2-bit saturating up/down counter.
module sat_ctr2 (
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_pred_lht.sv
// Fetch-side predictor: BTB + local history table + PHT of 2-bit counters,
// registered one-cycle lookup with write-first visibility of same-cycle updates.
module branch_pred_lht
    import rv32i_types::*;
#(
    parameter int IDX_BITS  = 8,
    parameter int HIST_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    input  logic                 fetch_stall,
    input  logic                 flush,
    output logic                 pred_valid,
    output logic [31:0]          pred_pc,
    output logic                 pred_bp,
    output logic [31:0]          pred_addr,
    output logic                 pred_lht_valid,
    output logic [HIST_BITS-1:0] pred_lht,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [HIST_BITS-1:0] upd_lht_in,
    input  logic                 btb_web,
    input  logic [IDX_BITS-1:0]  btb_addr,
    input  logic [31:0]          btb_din
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [31:0]          btb_tgt_q [ENTRIES];
    logic [31:0]          btb_tgt_d [ENTRIES];
    logic [ENTRIES-1:0]   btb_v_q;
    logic [ENTRIES-1:0]   btb_v_d;
    logic [HIST_BITS-1:0] lht_q [ENTRIES];
    logic [HIST_BITS-1:0] lht_d [ENTRIES];
    logic [ENTRIES-1:0]   lht_v_q;
    logic [ENTRIES-1:0]   lht_v_d;
    logic [1:0]           pht_q [ENTRIES];
    logic [1:0]           pht_d [ENTRIES];

    logic                 pred_valid_q, pred_valid_d;
    logic [31:0]          pred_pc_q, pred_pc_d;
    bp_pred_t             pred_q, pred_d;

    logic [IDX_BITS-1:0]  upd_idx;
    logic [IDX_BITS-1:0]  upd_pht_idx;
    logic [1:0]           upd_ctr_nxt;

    logic [IDX_BITS-1:0]  look_idx;
    logic [IDX_BITS-1:0]  look_pht_idx;
    logic [HIST_BITS-1:0] look_hist;
    bp_pred_t             look;

    // The PHT is trained on the history that preceded this outcome.
    assign upd_idx     = upd_pc[IDX_BITS+1:2];
    assign upd_pht_idx = {upd_lht_in[IDX_BITS-1:1], upd_pc[2]};

    sat_ctr2 u_sat_ctr2 (
        .ctr_i (pht_q[upd_pht_idx]),
        .inc_i (upd_lht_in[0]),
        .ctr_o (upd_ctr_nxt)
    );

    always_comb begin
        btb_tgt_d = btb_tgt_q;
        btb_v_d   = btb_v_q;
        lht_d     = lht_q;
        lht_v_d   = lht_v_q;
        pht_d     = pht_q;
        if (!btb_web) begin
            btb_tgt_d[btb_addr] = btb_din;
            btb_v_d[btb_addr]   = 1'b1;
        end
        if (upd_valid) begin
            lht_d[upd_idx]       = upd_lht_in;
            lht_v_d[upd_idx]     = 1'b1;
            pht_d[upd_pht_idx]   = upd_ctr_nxt;
        end
    end

    // Reading the next-state tables gives write-first bypass for free.
    always_comb begin
        look_idx       = fetch_pc[IDX_BITS+1:2];
        look_hist      = lht_v_d[look_idx] ? lht_d[look_idx] : '0;
        look_pht_idx   = {look_hist[IDX_BITS-2:0], fetch_pc[2]};
        look.bp        = btb_v_d[look_idx] & pht_d[look_pht_idx][1];
        look.bp_addr   = look.bp ? btb_tgt_d[look_idx] : fetch_pc + 32'd4;
        look.lht_valid = lht_v_d[look_idx];
        look.lht_true  = look_hist;
    end

    always_comb begin
        pred_valid_d = pred_valid_q;
        pred_pc_d    = pred_pc_q;
        pred_d       = pred_q;
        if (flush) begin
            pred_valid_d = 1'b0;
        end else if (!fetch_stall) begin
            pred_valid_d = fetch_valid;
            if (fetch_valid) begin
                pred_pc_d = fetch_pc;
                pred_d    = look;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_v_q      <= '0;
            lht_v_q      <= '0;
            for (int k = 0; k < ENTRIES; k++) pht_q[k] <= PHT_INIT;
            pred_valid_q <= 1'b0;
            pred_pc_q    <= '0;
            pred_q       <= '0;
        end else begin
            btb_v_q      <= btb_v_d;
            lht_v_q      <= lht_v_d;
            pht_q        <= pht_d;
            pred_valid_q <= pred_valid_d;
            pred_pc_q    <= pred_pc_d;
            pred_q       <= pred_d;
        end
    end

    // Target and history payloads are qualified by their valid bits.
    always_ff @(posedge clk) begin
        btb_tgt_q <= btb_tgt_d;
        lht_q     <= lht_d;
    end

    assign pred_valid     = pred_valid_q;
    assign pred_pc        = pred_pc_q;
    assign pred_bp        = pred_q.bp;
    assign pred_addr      = pred_q.bp_addr;
    assign pred_lht_valid = pred_q.lht_valid;
    assign pred_lht       = pred_q.lht_true;

endmodule
